// File: rtl/alu_pipe_if.sv
// Handshake/data bundle for alu_pipe: issue side (in_*, a, b, ctl) and writeback side (out_*, result, flags).
// The issue/writeback logic uses the master modport; alu_pipe uses the slave modport.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             cf;

    modport master (
        output in_valid, a, b, ctl, out_ready,
        input  in_ready, out_valid, alu, carry, zero, neg, ovf, cf
    );

    modport slave (
        input  in_valid, a, b, ctl, out_ready,
        output in_ready, out_valid, alu, carry, zero, neg, ovf, cf
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU with carry-flag chaining: the result is computed at accept and then carried
// through STAGES registers under a global valid/ready stall.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    alu_pipe_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_PASS = 4'h0,
        OP_INC  = 4'h1,
        OP_DEC  = 4'h2,
        OP_ADD  = 4'h3,
        OP_ADC  = 4'h4,
        OP_SUB  = 4'h5,
        OP_SBB  = 4'h6,
        OP_AND  = 4'h7,
        OP_OR   = 4'h8,
        OP_XOR  = 4'h9,
        OP_SHL  = 4'hA,
        OP_SHR  = 4'hB,
        OP_ROL  = 4'hC,
        OP_ROR  = 4'hD,
        OP_CLC  = 4'hE,
        OP_STC  = 4'hF
    } op_e;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] alu;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
    } stage_t;

    localparam int               MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    op_e              op;
    logic             cf_q;
    logic             accept;
    logic             advance;
    stage_t           fresh;
    stage_t           pipe [STAGES];

    logic [WIDTH-1:0] add_x, add_y, sub_x, sub_y;
    logic             add_ci, sub_ci;
    logic [WIDTH:0]   add_r, sub_r;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    assign op      = op_e'(bus.ctl);
    // One global stall: every stage moves together, bubbles included.
    assign advance = !bus.out_valid || bus.out_ready;
    assign accept  = bus.in_valid && advance;

    // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latch).
    always_comb begin
        add_x  = bus.a;
        add_y  = bus.b;
        add_ci = 1'b0;
        sub_x  = bus.a;
        sub_y  = bus.b;
        sub_ci = 1'b0;
        if (op == OP_INC) begin
            add_x = bus.b;
            add_y = ONE;
        end
        if (op == OP_DEC) begin
            sub_x = bus.b;
            sub_y = ONE;
        end
        if (op == OP_ADC) add_ci = cf_q;
        if (op == OP_SBB) sub_ci = cf_q;

        add_r = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
        // Bit WIDTH of the extended difference is the borrow.
        sub_r = {1'b0, sub_x} - {1'b0, sub_y} - {{WIDTH{1'b0}}, sub_ci};

        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_PASS: res = bus.b;
            OP_INC, OP_ADD, OP_ADC: begin
                res   = add_r[MSB:0];
                res_c = add_r[WIDTH];
                res_v = (add_x[MSB] == add_y[MSB]) && (add_r[MSB] != add_x[MSB]);
            end
            OP_DEC, OP_SUB, OP_SBB: begin
                res   = sub_r[MSB:0];
                res_c = sub_r[WIDTH];
                res_v = (sub_x[MSB] != sub_y[MSB]) && (sub_r[MSB] != sub_x[MSB]);
            end
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_SHL: begin
                res   = {bus.b[MSB-1:0], 1'b0};
                res_c = bus.b[MSB];
            end
            OP_SHR: begin
                res   = {1'b0, bus.b[MSB:1]};
                res_c = bus.b[0];
            end
            OP_ROL: begin
                res   = {bus.b[MSB-1:0], bus.b[MSB]};
                res_c = bus.b[MSB];
            end
            OP_ROR: begin
                res   = {bus.b[0], bus.b[MSB:1]};
                res_c = bus.b[0];
            end
            OP_CLC:  res_c = 1'b0;
            OP_STC:  res_c = 1'b1;
        endcase

        fresh.valid = accept;
        fresh.alu   = res;
        fresh.carry = res_c;
        fresh.zero  = (res == '0);
        fresh.neg   = res[MSB];
        fresh.ovf   = res_v;
    end

    // NOTE: the stage array is reset in full (not just the valids) because alu and flags must read 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
            cf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every stage sample its predecessor's old value in the same edge.
            if (accept) cf_q <= res_c;
            if (advance) begin
                pipe[0] <= fresh;
                for (int k = 1; k < STAGES; k++) pipe[k] <= pipe[k-1];
            end
            // Flush kills validity only; cf keeps whatever the same-cycle accept wrote.
            if (flush) begin
                for (int k = 0; k < STAGES; k++) pipe[k].valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = pipe[STAGES-1].valid;
    assign bus.alu       = pipe[STAGES-1].alu;
    assign bus.carry     = pipe[STAGES-1].carry;
    assign bus.zero      = pipe[STAGES-1].zero;
    assign bus.neg       = pipe[STAGES-1].neg;
    assign bus.ovf       = pipe[STAGES-1].ovf;
    assign bus.cf        = cf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8, STAGES=2): opcodes, flags, carry chaining,
// backpressure, mid-stream reset and flush.
module tb_alu_pipe;
    localparam logic [3:0] PASS = 4'h0, INC = 4'h1, DEC = 4'h2, ADD = 4'h3, ADC = 4'h4,
                           SUB  = 4'h5, SBB = 4'h6, AND = 4'h7, OR  = 4'h8, XOR = 4'h9,
                           SHL  = 4'hA, SHR = 4'hB, ROL = 4'hC, ROR = 4'hD, CLC = 4'hE,
                           STC  = 4'hF;

    logic clk;
    logic reset;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_pipe_if #(.WIDTH(8)) bus ();

    alu_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issues one op with out_ready=1, checks cf one cycle after accept, latency and the result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                          input logic [7:0] vb, input logic [7:0] e_alu, input logic e_c,
                          input logic e_z, input logic e_n, input logic e_v);
        int lat;
        @(negedge clk);
        bus.ctl       = op;
        bus.a         = va;
        bus.b         = vb;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, ".cf"}, 32'(bus.cf), 32'(e_c));
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 2);
        check({tag, ".alu"},   32'(bus.alu),   32'(e_alu));
        check({tag, ".carry"}, 32'(bus.carry), 32'(e_c));
        check({tag, ".zero"},  32'(bus.zero),  32'(e_z));
        check({tag, ".neg"},   32'(bus.neg),   32'(e_n));
        check({tag, ".ovf"},   32'(bus.ovf),   32'(e_v));
    endtask

    initial begin
        logic [7:0] got [$];
        logic [7:0] av [4];
        logic [7:0] ev [4];
        int         idx;

        av = '{8'h01, 8'h02, 8'h03, 8'h04};
        ev = '{8'h02, 8'h04, 8'h06, 8'h08};

        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ctl       = '0;
        #12;
        check("rst.out_valid", 32'(bus.out_valid), 0);
        check("rst.alu",       32'(bus.alu),       0);
        check("rst.cf",        32'(bus.cf),        0);
        check("rst.in_ready",  32'(bus.in_ready),  1);
        @(negedge clk);
        reset = 1'b1;

        // Arithmetic and carry chaining
        run_op("add_f0_20",  ADD, 8'hF0, 8'h20, 8'h10, 1, 0, 0, 0);
        run_op("adc_chain",  ADC, 8'h01, 8'h01, 8'h03, 0, 0, 0, 0);
        run_op("sbb_cf0",    SBB, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
        run_op("stc",        STC, 8'h12, 8'h34, 8'h00, 1, 1, 0, 0);
        run_op("sbb_cf1",    SBB, 8'h00, 8'h00, 8'hFF, 1, 0, 1, 0);
        run_op("sub_ovf",    SUB, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1);
        run_op("add_ovf",    ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
        run_op("inc_wrap",   INC, 8'h00, 8'hFF, 8'h00, 1, 1, 0, 0);
        run_op("dec_ovf",    DEC, 8'h00, 8'h80, 8'h7F, 0, 0, 0, 1);
        run_op("dec_borrow", DEC, 8'h00, 8'h00, 8'hFF, 1, 0, 1, 0);
        // Shifts, rotates and logic
        run_op("shl_81",     SHL, 8'h00, 8'h81, 8'h02, 1, 0, 0, 0);
        run_op("ror_01",     ROR, 8'h00, 8'h01, 8'h80, 1, 0, 1, 0);
        run_op("shr_01",     SHR, 8'h00, 8'h01, 8'h00, 1, 1, 0, 0);
        run_op("rol_80",     ROL, 8'h00, 8'h80, 8'h01, 1, 0, 0, 0);
        run_op("and",        AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0);
        run_op("or",         OR,  8'hF0, 8'h0F, 8'hFF, 0, 0, 1, 0);
        run_op("xor",        XOR, 8'hAA, 8'hAA, 8'h00, 0, 1, 0, 0);
        run_op("pass",       PASS, 8'h55, 8'h9C, 8'h9C, 0, 0, 1, 0);
        run_op("clc",        CLC, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 0);

        // Backpressure: four ADDs with the consumer stalled for six cycles
        idx = 0;
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 6);
            if (idx < 4) begin
                bus.in_valid = 1'b1;
                bus.ctl      = ADD;
                bus.a        = av[idx];
                bus.b        = av[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                check("stall.hold_alu", 32'(bus.alu), 32'h02);
                check("stall.in_ready", 32'(bus.in_ready), 0);
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.alu);
            if (bus.in_valid && bus.in_ready) idx++;
        end
        bus.in_valid = 1'b0;
        check("stream.count", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) check($sformatf("stream.res%0d", i), 32'(got[i]), 32'(ev[i]));
        end
        @(negedge clk);
        check("stream.drain", 32'(bus.out_valid), 0);

        // Flush with two ops in flight; cf must survive
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ctl       = ADD;
        bus.a         = 8'hF0;
        bus.b         = 8'h20;
        @(negedge clk);
        bus.a = 8'h80;
        bus.b = 8'h80;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("flush.pre_valid", 32'(bus.out_valid), 1);
        check("flush.pre_cf",    32'(bus.cf),        1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.out_valid", 32'(bus.out_valid), 0);
        check("flush.cf_kept",   32'(bus.cf),        1);
        repeat (2) @(negedge clk);
        check("flush.stays_empty", 32'(bus.out_valid), 0);
        run_op("post_flush_adc", ADC, 8'h01, 8'h01, 8'h03, 0, 0, 0, 0);

        // Op accepted in the flush cycle: discarded, but still writes cf
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.ctl       = STC;
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_acc.cf",        32'(bus.cf),        1);
        check("flush_acc.out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("flush_acc.discarded", 32'(bus.out_valid), 0);

        // Asynchronous reset with two ops in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ctl       = ADD;
        bus.a         = 8'hF0;
        bus.b         = 8'h20;
        @(negedge clk);
        bus.a = 8'h80;
        bus.b = 8'h80;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid_rst.pre_alu", 32'(bus.alu), 32'h10);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst.out_valid", 32'(bus.out_valid), 0);
        check("mid_rst.alu",       32'(bus.alu),       0);
        check("mid_rst.carry",     32'(bus.carry),     0);
        check("mid_rst.zero",      32'(bus.zero),      0);
        check("mid_rst.neg",       32'(bus.neg),       0);
        check("mid_rst.ovf",       32'(bus.ovf),       0);
        check("mid_rst.cf",        32'(bus.cf),        0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst.no_ghost", 32'(bus.out_valid), 0);
        run_op("post_rst_adc", ADC, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
